// File: rtl/lsu_dram_bridge.sv
// Load/store bridge from the EX/MEM request port to a word-wide distributed RAM.
// Sub-word stores are done as read-modify-write; loads are lane-aligned and extended.
module lsu_dram_bridge #(
  parameter int DRAM_AW = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic [DRAM_AW-1:0] dram_a,
  input  logic [31:0]        dram_spo,
  output logic [31:0]        dram_d,
  output logic               dram_we
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic               req_ready_reg, req_ready_next;
  logic               resp_valid_reg, resp_valid_next;
  logic               resp_err_reg, resp_err_next;
  logic [31:0]        resp_rdata_reg, resp_rdata_next;
  logic               dram_we_reg, dram_we_next;
  logic [DRAM_AW-1:0] dram_a_reg, dram_a_next;
  logic [31:0]        dram_d_reg, dram_d_next;
  logic [1:0]         size_reg, size_next;
  logic               unsigned_reg, unsigned_next;
  logic [1:0]         lane_reg, lane_next;
  logic [15:0]        wdata_reg, wdata_next;

  logic        req_fire;
  logic        req_bad;
  logic [31:0] load_shift;
  logic [31:0] load_ext;
  logic [31:0] ins_word;
  logic [3:0]  lane_mask;
  logic [31:0] merged;

  // Address bits above the RAM window are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:DRAM_AW+2];

  assign req_fire = req_valid & req_ready_reg;
  assign req_bad  = (req_size == 2'b11) |
                    ((req_size == 2'b01) & req_addr[0]) |
                    ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

  // Load path: aligned requests only, so a byte shift by the lane works for halves too.
  assign load_shift = dram_spo >> {lane_reg, 3'b000};

  always_comb begin
    load_ext = load_shift;
    case (size_reg)
      2'b00:   load_ext = unsigned_reg ? {24'd0, load_shift[7:0]}
                                       : {{24{load_shift[7]}}, load_shift[7:0]};
      2'b01:   load_ext = unsigned_reg ? {16'd0, load_shift[15:0]}
                                       : {{16{load_shift[15]}}, load_shift[15:0]};
      default: load_ext = load_shift;
    endcase
  end

  // Store merge: replicate the new data across lanes, then pick per byte.
  assign ins_word = (size_reg == 2'b00) ? {4{wdata_reg[7:0]}} : {2{wdata_reg[15:0]}};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[gi] = (size_reg == 2'b00) ? (lane_reg == 2'(gi))
                                                 : (lane_reg[1] == 1'(gi >> 1));
      assign merged[8*gi +: 8] = lane_mask[gi] ? ins_word[8*gi +: 8] : dram_spo[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    resp_err_next   = resp_err_reg;
    resp_rdata_next = resp_rdata_reg;
    dram_we_next    = 1'b0;
    dram_a_next     = dram_a_reg;
    dram_d_next     = dram_d_reg;
    size_next       = size_reg;
    unsigned_next   = unsigned_reg;
    lane_next       = lane_reg;
    wdata_next      = wdata_reg;

    case (state_reg)
      IDLE: begin
        if (req_fire) begin
          size_next     = req_size;
          unsigned_next = req_unsigned;
          lane_next     = req_addr[1:0];
          wdata_next    = req_wdata[15:0];
          if (req_bad) begin
            state_next      = RESP;
            resp_err_next   = 1'b1;
            resp_rdata_next = 32'd0;
          end else begin
            dram_a_next = req_addr[DRAM_AW+1:2];
            if (!req_we) begin
              state_next = LOAD;
            end else if (req_size == 2'b10) begin
              state_next   = WRITE;
              dram_we_next = 1'b1;
              dram_d_next  = req_wdata;
            end else begin
              state_next = RMW_RD;
            end
          end
        end
      end
      LOAD: begin
        state_next      = RESP;
        resp_err_next   = 1'b0;
        resp_rdata_next = load_ext;
      end
      RMW_RD: begin
        state_next   = WRITE;
        dram_we_next = 1'b1;
        dram_d_next  = merged;
      end
      WRITE: begin
        state_next      = RESP;
        resp_err_next   = 1'b0;
        resp_rdata_next = 32'd0;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Handshake outputs are registered copies of the next state.
    req_ready_next  = (state_next == IDLE);
    resp_valid_next = (state_next == RESP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      req_ready_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'd0;
      dram_we_reg    <= 1'b0;
      dram_a_reg     <= '0;
      dram_d_reg     <= 32'd0;
      size_reg       <= 2'b00;
      unsigned_reg   <= 1'b0;
      lane_reg       <= 2'b00;
      wdata_reg      <= 16'd0;
    end else begin
      state_reg      <= state_next;
      req_ready_reg  <= req_ready_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
      dram_we_reg    <= dram_we_next;
      dram_a_reg     <= dram_a_next;
      dram_d_reg     <= dram_d_next;
      size_reg       <= size_next;
      unsigned_reg   <= unsigned_next;
      lane_reg       <= lane_next;
      wdata_reg      <= wdata_next;
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_rdata = resp_rdata_reg;
  assign dram_we    = dram_we_reg;
  assign dram_a     = dram_a_reg;
  assign dram_d     = dram_d_reg;

endmodule

// File: doc/lsu_dram_bridge.md
Name: lsu_dram_bridge

Overview:
- Load/store bridge between the EX/MEM stage memory request and the word-wide distributed data RAM port (a/spo/d/we).
- Converts byte, halfword and word accesses into word-granular RAM traffic.
- Sub-word stores use read-modify-write.
- Loads are aligned and sign- or zero-extended.
- Holds the response until the pipeline accepts it.

Parameters:
- DRAM_AW, 16, RAM word-address width; dram_a = addr[DRAM_AW+1:2].

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  bridge can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  input  1  load zero-extends when 1
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  response present
- resp_ready  input  1  pipeline accepts response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned or reserved-size request
- dram_a  output  DRAM_AW  RAM word address
- dram_spo  input  32  RAM combinational read data
- dram_d  output  32  RAM write data
- dram_we  output  1  RAM write enable

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on resetn. While resetn=0, state=IDLE and all registered outputs are 0: req_ready=0 during reset; resp_valid, resp_err, resp_rdata, dram_we, dram_a and dram_d are 0.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - Handshake when req_valid & req_ready; on it, register we, size, unsigned, addr and wdata.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0) or size=11: go to RESP with resp_err=1 and rdata=0. No RAM access.
  - Load: go to LOAD.
  - Word store: go to WRITE with merge data = wdata.
  - Byte/half store: go to RMW_RD.
- LOAD:
  - dram_a = registered addr word index.
  - Capture dram_spo and select the lane by addr[1:0]: byte lane = addr[1:0]; half lane = addr[1].
  - Extend per size/unsigned into resp_rdata, then go to RESP.
- RMW_RD:
  - Drive dram_a and capture dram_spo.
  - Replace the byte/half lane with wdata[7:0]/wdata[15:0]; all other bytes unchanged.
  - Go to WRITE.
- WRITE: dram_we=1 for exactly this cycle, with dram_a and dram_d = merged word. Then go to RESP with rdata=0 and err=0.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are stable.
  - On resp_ready, go to IDLE.
  - req_ready=0 in every non-IDLE state, so there is no request overlap.
- dram_we is 1 only in WRITE; never asserted on error or load.
- Latency from the handshake cycle T, with resp_ready held at 1:
  - error: resp_valid at T+1
  - load: T+2
  - word store: T+2
  - sub-word store: T+3
  - Next request is accepted the cycle after the resp handshake.
- Back-pressure: resp_ready=0 holds RESP indefinitely with outputs unchanged.
- Upper address bits above DRAM_AW+1 are ignored.
- Reset mid-RMW: if resetn falls in RMW_RD, there is no write; return to IDLE. A write is never split across reset.
- dram_a and dram_d are don't-care when dram_we=0 except in LOAD/RMW_RD; they must not glitch dram_we.

Test Plan:
- RAM[3]=0x8899AABB; load byte addr 0x0000000F signed -> resp_rdata=0xFFFFFF88 at T+2. Same access unsigned -> 0x00000088.
- RAM[3]=0x8899AABB; store byte 0x11 to addr 0x0000000D -> exactly one dram_we pulse at T+2 with dram_a=3, dram_d=0x889911BB; resp_valid at T+3.
- Store half 0x1234 at addr 0x00000006 over RAM[1]=0xFFFFFFFF -> dram_d=0x1234FFFF. Subsequent load half unsigned at addr 0x6 -> 0x00001234.
- Load word at addr 0x00000002 -> resp_err=1, resp_rdata=0, resp_valid at T+1, no dram_we. Same for size=11.
- Word load with resp_ready=0 for 5 cycles -> resp_valid and rdata held constant; req_ready=0; a new req_valid is ignored until the resp handshake.
- Assert resetn=0 during RMW_RD of a byte store -> no dram_we pulse, RAM unchanged, all outputs 0. After release, req_ready=1 in IDLE.
